spi_probe_mux: RTL



---
 rtl/spi_probe_pkg.sv | 46 ++++
 rtl/spi_probe_mux_sync_bus.sv | 26 ++
 rtl/spi_probe_mux.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_probe_pkg.sv
// Shared types, defaults and select-decoding helper for spi_probe_mux.
`timescale 1ns/1ps
package spi_probe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_CONFLICT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_MANY = 2'd2
  } sel_cnt_e;

  typedef struct packed {
    sel_cnt_e   cnt;
    logic [2:0] idx;
  } sel_info_t;

  localparam int   MAX_N_SS        = 8;
  localparam int   DEF_N_SS        = 2;
  localparam int   DEF_WIDTH       = 8;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam logic DEF_IDLE_LEVEL  = 1'b1;

  // Classifies the active-high select mask as none/one/many; idx is valid for SEL_ONE.
  function automatic sel_info_t decode_sel(input logic [MAX_N_SS-1:0] low);
    sel_info_t  r;
    logic [3:0] n;
    n     = '0;
    r.idx = '0;
    for (int i = 0; i < MAX_N_SS; i++) begin
      if (low[i]) begin
        n     = n + 4'd1;
        r.idx = 3'(i);
      end
    end
    if (n == 4'd0)      r.cnt = SEL_NONE;
    else if (n == 4'd1) r.cnt = SEL_ONE;
    else                r.cnt = SEL_MANY;
    return r;
  endfunction

endpackage

// File: rtl/spi_probe_mux_sync_bus.sv
// Multi-bit flop-chain synchroniser; every stage resets to all-ones (idle SPI levels).
`timescale 1ns/1ps
module sync_bus #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '1;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/spi_probe_mux.sv
// SPI MISO probe/tap: routes the single active slave's MISO to a probe pin and deserialises it.
// Optional macro SPI_PROBE_TRISTATE_EN: probe is high-Z outside ACTIVE and miso_probe_oe is added.
`timescale 1ns/1ps
module spi_probe_mux
  import spi_probe_pkg::*;
#(
  parameter int   N_SS        = DEF_N_SS,
  parameter int   WIDTH       = DEF_WIDTH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL,
  localparam int  IDXW        = (N_SS > 1) ? $clog2(N_SS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic [N_SS-1:0]  ss_n,
  input  logic [N_SS-1:0]  miso,
  output logic             miso_probe,
`ifdef SPI_PROBE_TRISTATE_EN
  output logic             miso_probe_oe,
`endif
  output logic [IDXW-1:0]  sel_idx,
  output logic             sel_valid,
  output logic             conflict,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [0:0]      sclk_s;
  logic [N_SS-1:0] ss_s;
  logic [N_SS-1:0] miso_s;

  sync_bus #(.W(1),    .STAGES(SYNC_STAGES)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
  sync_bus #(.W(N_SS), .STAGES(SYNC_STAGES)) u_sync_ss   (.clk(clk), .rst_n(rst_n), .d_i(ss_n), .q_o(ss_s));
  sync_bus #(.W(N_SS), .STAGES(SYNC_STAGES)) u_sync_miso (.clk(clk), .rst_n(rst_n), .d_i(miso), .q_o(miso_s));

  logic sclk_dly_q;
  logic sclk_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sclk_dly_q <= 1'b1;
    else        sclk_dly_q <= sclk_s[0];
  end

  assign sclk_rise = sclk_s[0] & ~sclk_dly_q;

  logic [MAX_N_SS-1:0] ss_low_ext;
  sel_info_t           info;

  always_comb begin
    ss_low_ext            = '0;
    ss_low_ext[N_SS-1:0]  = ~ss_s;
  end

  assign info = decode_sel(ss_low_ext);

  state_e          state_q, state_d;
  logic [IDXW-1:0] sel_idx_q, sel_idx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_idx_q <= sel_idx_d;
    end
  end

  // The latched slave releasing always wins: we drop to IDLE and re-decode next cycle.
  always_comb begin
    state_d   = state_q;
    sel_idx_d = sel_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (info.cnt == SEL_ONE) begin
          state_d   = ST_ACTIVE;
          sel_idx_d = IDXW'(info.idx);
        end else if (info.cnt == SEL_MANY) begin
          state_d = ST_CONFLICT;
        end
      end
      ST_ACTIVE: begin
        if (ss_s[sel_idx_q])            state_d = ST_IDLE;
        else if (info.cnt == SEL_MANY)  state_d = ST_CONFLICT;
      end
      ST_CONFLICT: begin
        if (info.cnt == SEL_NONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic sel_valid_d, conflict_d, probe_d;
  logic sel_valid_q, conflict_q, probe_q;

  always_comb begin
    sel_valid_d = (state_d == ST_ACTIVE);
    conflict_d  = (state_d == ST_CONFLICT);
    probe_d     = sel_valid_d ? miso_s[sel_idx_d] : IDLE_LEVEL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_valid_q <= 1'b0;
      conflict_q  <= 1'b0;
      probe_q     <= IDLE_LEVEL;
    end else begin
      sel_valid_q <= sel_valid_d;
      conflict_q  <= conflict_d;
      probe_q     <= probe_d;
    end
  end

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-2:0] shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic [WIDTH-1:0] word_d;

  assign word_d = {shift_q, miso_s[sel_idx_q]};

  // Only shift when we were already ACTIVE and are staying there; any exit drops the partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (state_d != ST_ACTIVE) begin
        cnt_q <= '0;
      end else if (state_q == ST_ACTIVE && sclk_rise) begin
        shift_q <= word_d[WIDTH-2:0];
        if (cnt_q == CW'(WIDTH - 1)) begin
          rx_data_q  <= word_d;
          rx_valid_q <= 1'b1;
          cnt_q      <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef SPI_PROBE_TRISTATE_EN
  assign miso_probe    = sel_valid_q ? probe_q : 1'bz;
  assign miso_probe_oe = sel_valid_q;
`else
  assign miso_probe    = probe_q;
`endif

  assign sel_idx   = sel_idx_q;
  assign sel_valid = sel_valid_q;
  assign conflict  = conflict_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign dbg_state = state_q;

endmodule
